// File: rtl/xz_opmode_sequencer_if.sv
// Command/status bundle between the X/Z opmode sequencer and its controller.
// The controller (master) issues commands and aborts; the sequencer (slave)
// drives the DSP mux selects, register enables and status.
interface xz_opmode_sequencer_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic             abort;
    logic [1:0]       x_sel;
    logic [1:0]       z_sel;
    logic             ce_m;
    logic             ce_p;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] term_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_len, abort,
        input  cmd_ready, x_sel, z_sel, ce_m, ce_p, busy, done, term_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, abort,
        output cmd_ready, x_sel, z_sel, ce_m, ce_p, busy, done, term_cnt
    );
endinterface

// File: rtl/xz_opmode_sequencer.sv
// X/Z operand-mux and M/P enable sequencer for the DSP slice.
// Accepts one command per handshake and steps the selects through CLEAR, MAC,
// ADD_C and PASS_CAT sequences, pulsing done at the end.
// Optional feature: define XZ_SEQ_ROUND_EN to load C (z_sel=11) on the first
// ACCUM cycle of a MAC as a rounding constant; otherwise that cycle uses z_sel=00.
module xz_opmode_sequencer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned PIPE_LAT = 2   // legal 1..3
) (
    input logic                  clk,
    input logic                  rst_n,
    xz_opmode_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StFill, StAccum, StExec, StDone} state_e;

    localparam logic [1:0] OpClear   = 2'b00;
    localparam logic [1:0] OpMac     = 2'b01;
    localparam logic [1:0] OpAddC    = 2'b10;
    localparam logic [1:0] OpPassCat = 2'b11;

    localparam logic [1:0] XZero = 2'b00;
    localparam logic [1:0] XM    = 2'b01;
    localparam logic [1:0] XP    = 2'b10;
    localparam logic [1:0] XCat  = 2'b11;
    localparam logic [1:0] ZZero = 2'b00;
    localparam logic [1:0] ZP    = 2'b10;
    localparam logic [1:0] ZC    = 2'b11;

`ifdef XZ_SEQ_ROUND_EN
    localparam logic [1:0] ZFirstAccum = ZC;
`else
    localparam logic [1:0] ZFirstAccum = ZZero;
`endif

    localparam logic [1:0]       FillLast = 2'(PIPE_LAT);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic [1:0]       x_sel_q, x_sel_d;
    logic [1:0]       z_sel_q, z_sel_d;
    logic             ce_m_q, ce_m_d;
    logic             ce_p_q, ce_p_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, command latch and term counter.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        len_d      = len_q;
        fill_cnt_d = fill_cnt_q;
        term_cnt_d = term_cnt_q;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        op_d       = bus.cmd_op;
                        // A zero-length MAC still accumulates one term.
                        len_d      = (bus.cmd_len == '0) ? CNT_W'(1) : bus.cmd_len;
                        fill_cnt_d = 2'd1;
                        term_cnt_d = '0;
                        state_d    = (bus.cmd_op == OpMac) ? StFill : StExec;
                    end
                end
                StFill: begin
                    if (fill_cnt_q >= FillLast) begin
                        state_d = StAccum;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 2'd1;
                    end
                end
                StAccum: begin
                    // term_cnt_q already includes the current cycle.
                    if (term_cnt_q >= len_q) begin
                        state_d = StDone;
                    end
                end
                StExec:  state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // Count the term being accumulated in the upcoming ACCUM cycle; saturate.
        if (state_d == StAccum && term_cnt_q != CntMax) begin
            term_cnt_d = term_cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs decoded from the next state.
    always_comb begin
        x_sel_d = XZero;
        z_sel_d = ZZero;
        ce_m_d  = 1'b0;
        ce_p_d  = 1'b0;
        busy_d  = (state_d != StIdle);
        done_d  = 1'b0;

        unique case (state_d)
            StFill: begin
                ce_m_d = 1'b1;
            end
            StAccum: begin
                ce_m_d  = 1'b1;
                ce_p_d  = 1'b1;
                x_sel_d = XM;
                // First term seeds P; later terms feed back P.
                z_sel_d = (state_q == StAccum) ? ZP : ZFirstAccum;
            end
            StExec: begin
                ce_p_d = 1'b1;
                unique case (op_d)
                    OpAddC: begin
                        x_sel_d = XP;
                        z_sel_d = ZC;
                    end
                    OpPassCat: begin
                        x_sel_d = XCat;
                        z_sel_d = ZZero;
                    end
                    OpClear, OpMac: begin
                        x_sel_d = XZero;
                        z_sel_d = ZZero;
                    end
                    default: ;
                endcase
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OpClear;
            len_q      <= '0;
            fill_cnt_q <= '0;
            term_cnt_q <= '0;
            x_sel_q    <= XZero;
            z_sel_q    <= ZZero;
            ce_m_q     <= 1'b0;
            ce_p_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            fill_cnt_q <= fill_cnt_d;
            term_cnt_q <= term_cnt_d;
            x_sel_q    <= x_sel_d;
            z_sel_q    <= z_sel_d;
            ce_m_q     <= ce_m_d;
            ce_p_q     <= ce_p_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.x_sel     = x_sel_q;
    assign bus.z_sel     = z_sel_q;
    assign bus.ce_m      = ce_m_q;
    assign bus.ce_p      = ce_p_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.term_cnt  = term_cnt_q;

endmodule
